// File: rtl/scope_pkg.sv
// Shared definitions for the scope display datapath.
// Holds the default raster geometry, the sample and row widths, the constants
// that map a sample value onto a screen row, the display colours, and the
// per-pixel record that travels down the render pipeline.
package scope_pkg;

  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 480;
  localparam int COORD_W     = 11;
  localparam int SAMPLE_W    = 14;
  localparam int ROW_W       = 9;

  // row = (V_ACTIVE-1) - ((sample * SCALE_MUL) >> SCALE_SHIFT).
  // 16383 * 15 = 245745 fits in 18 bits, and 245745 >> 9 = 479.
  localparam int SCALE_MUL   = 15;
  localparam int SCALE_SHIFT = 9;
  localparam int PROD_W      = 18;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COLOR_TRACE = 24'h00FF00;
  localparam rgb_t COLOR_AXIS  = 24'h808080;
  localparam rgb_t COLOR_GRID  = 24'h404040;
  localparam rgb_t COLOR_BG    = 24'h000000;

  // One pixel's worth of context. The grid counters are reduced to
  // "on a grid line" flags as soon as they are known.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               visible;
    logic               hsync;
    logic               vsync;
    logic               gridX;
    logic               gridY;
  } pix_stage_t;

endpackage

// File: rtl/scope_row_scale.sv
// Converts a 14-bit trace sample into the screen row it is drawn on.
// Full scale (16383) lands on the top row, zero on the bottom row.
// The result is registered, so the row appears one clock after the sample.
// Ports:
//   clock     pixel clock
//   reset     asynchronous, active-high
//   sample_i  unsigned sample value
//   row_o     registered screen row, always within 0..V_ACTIVE-1
module scope_row_scale #(
  parameter int V_ACTIVE = scope_pkg::V_ACTIVE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [scope_pkg::SAMPLE_W-1:0] sample_i,
  output logic [scope_pkg::ROW_W-1:0]    row_o
);
  import scope_pkg::*;

  logic [PROD_W-1:0] product;
  logic [ROW_W-1:0]  row_d;
  logic [ROW_W-1:0]  row_q;

  // The shifted product never exceeds V_ACTIVE-1, so the subtraction
  // cannot underflow and the truncation to ROW_W bits is lossless.
  always_comb begin
    product = PROD_W'(sample_i) * PROD_W'(SCALE_MUL);
    row_d   = ROW_W'(PROD_W'(V_ACTIVE - 1) - (product >> SCALE_SHIFT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/scope_trace_render.sv
// Display stage of the scope: turns the raster position and the captured
// trace into RGB for the VGA DAC. Draws a graticule grid, centre axes and the
// waveform as a vertically connected line. Four-stage pipeline, one pixel per
// clock; syncs and data-enable are delayed to stay aligned with the colour.
// Ports:
//   clock, reset        pixel clock, asynchronous active-high reset
//   pixel_x, pixel_y    raster position from the timing generator
//   active              position is inside the visible area
//   hsync_in, vsync_in  syncs from the timing generator
//   sample_x            column address to the sample store
//   sample_data         store read data, valid one clock after sample_x
//   red, green, blue    pixel colour, 4 clocks after pixel_x
//   hsync_out, vsync_out, de_out  syncs and active, delayed 4 clocks
module scope_trace_render #(
  parameter int   H_ACTIVE  = scope_pkg::H_ACTIVE,
  parameter int   V_ACTIVE  = scope_pkg::V_ACTIVE,
  parameter int   GRID_X    = 100,
  parameter int   GRID_Y    = 60,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [scope_pkg::COORD_W-1:0]  pixel_x,
  input  logic [scope_pkg::COORD_W-1:0]  pixel_y,
  input  logic                           active,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic [scope_pkg::COORD_W-1:0]  sample_x,
  input  logic [scope_pkg::SAMPLE_W-1:0] sample_data,
  output logic [7:0]                     red,
  output logic [7:0]                     green,
  output logic [7:0]                     blue,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           de_out
);
  import scope_pkg::*;

  localparam int GX_W = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int GY_W = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;

  localparam pix_stage_t STAGE_RESET = '{
    x: '0, y: '0, active: 1'b0, visible: 1'b0,
    hsync: SYNC_IDLE, vsync: SYNC_IDLE, gridX: 1'b0, gridY: 1'b0
  };

  logic [GX_W-1:0]    gxCnt_d, gxCnt_q;
  logic [GY_W-1:0]    gyCnt_d, gyCnt_q;
  logic               visible_d;
  logic [COORD_W-1:0] sampleX_d, sampleX_q;
  pix_stage_t         s1_d, s1_q, s2_q, s3_q;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   prevRow_q;
  logic [ROW_W-1:0]   prevEff;
  logic [ROW_W-1:0]   rowLo, rowHi;
  rgb_t               rgb_d, rgb_q;
  logic               hsOut_q, vsOut_q, deOut_q;

  // Stage 1 next-state. Columns past H_ACTIVE are treated as not visible
  // even while active is high, so they render black and never address the
  // store. gx counts pixels since column 0; gy counts lines since row 0 and
  // steps on the rising edge of active, i.e. the first visible pixel.
  always_comb begin
    visible_d = active && (pixel_x < COORD_W'(H_ACTIVE));
    sampleX_d = visible_d ? pixel_x : '0;

    if (pixel_x == '0) begin
      gxCnt_d = '0;
    end else if (gxCnt_q == GX_W'(GRID_X - 1)) begin
      gxCnt_d = '0;
    end else begin
      gxCnt_d = gxCnt_q + 1'b1;
    end

    if (pixel_y == '0) begin
      gyCnt_d = '0;
    end else if (active && !s1_q.active) begin
      gyCnt_d = (gyCnt_q == GY_W'(GRID_Y - 1)) ? '0 : gyCnt_q + 1'b1;
    end else begin
      gyCnt_d = gyCnt_q;
    end

    s1_d         = STAGE_RESET;
    s1_d.x       = pixel_x;
    s1_d.y       = pixel_y;
    s1_d.active  = active;
    s1_d.visible = visible_d;
    s1_d.hsync   = hsync_in;
    s1_d.vsync   = vsync_in;
    s1_d.gridX   = (gxCnt_d == '0);
    s1_d.gridY   = (gyCnt_d == '0);
  end

  // Stages 1-3. Stage 2 only waits out the store's registered read; the row
  // scaler registers alongside stage 3, so row and s3_q describe one pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gxCnt_q   <= '0;
      gyCnt_q   <= '0;
      sampleX_q <= '0;
      s1_q      <= STAGE_RESET;
      s2_q      <= STAGE_RESET;
      s3_q      <= STAGE_RESET;
      prevRow_q <= '0;
    end else begin
      gxCnt_q   <= gxCnt_d;
      gyCnt_q   <= gyCnt_d;
      sampleX_q <= sampleX_d;
      s1_q      <= s1_d;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      if (s3_q.active) begin
        prevRow_q <= row;
      end
    end
  end

  scope_row_scale #(
    .V_ACTIVE (V_ACTIVE)
  ) u_rowScale (
    .clock    (clock),
    .reset    (reset),
    .sample_i (sample_data),
    .row_o    (row)
  );

  // Stage 4 colour. The trace spans the rows between this column's sample
  // and the previous column's, which joins steep edges into a solid line.
  // Column 0 uses its own row so a line never joins the previous line's end.
  always_comb begin
    prevEff = (s3_q.x == '0) ? row : prevRow_q;
    rowLo   = (row < prevEff) ? row : prevEff;
    rowHi   = (row < prevEff) ? prevEff : row;

    if (!s3_q.visible) begin
      rgb_d = COLOR_BG;
    end else if ((s3_q.y >= COORD_W'(rowLo)) && (s3_q.y <= COORD_W'(rowHi))) begin
      rgb_d = COLOR_TRACE;
    end else if ((s3_q.x == COORD_W'(H_ACTIVE / 2)) || (s3_q.y == COORD_W'(V_ACTIVE / 2))) begin
      rgb_d = COLOR_AXIS;
    end else if (s3_q.gridX || s3_q.gridY) begin
      rgb_d = COLOR_GRID;
    end else begin
      rgb_d = COLOR_BG;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q   <= COLOR_BG;
      hsOut_q <= SYNC_IDLE;
      vsOut_q <= SYNC_IDLE;
      deOut_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsOut_q <= s3_q.hsync;
      vsOut_q <= s3_q.vsync;
      deOut_q <= s3_q.active;
    end
  end

  assign sample_x  = sampleX_q;
  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign hsync_out = hsOut_q;
  assign vsync_out = vsOut_q;
  assign de_out    = deOut_q;

endmodule
